// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants and types for the RV32I decoder
// Holds XLEN, RV32I major opcodes, funct7 patterns and the format enumeration.
package decode_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      ITYPE_R       = 3'd0,
      ITYPE_I       = 3'd1,
      ITYPE_S       = 3'd2,
      ITYPE_B       = 3'd3,
      ITYPE_U       = 3'd4,
      ITYPE_J       = 3'd5,
      ITYPE_ILLEGAL = 3'd7
   } itype_e;

endpackage

// File: rtl/decode_if.sv
// rtl/decode_if.sv - instruction-in / decoded-fields-out bundle for decode
// Ports: inst (to decoder); opcode, rd, funct3, rs1, rs2, funct7, imm, itype,
// reg_write, mem_read, mem_write, branch, jump, illegal (from decoder).
// master = instruction source, slave = decoder.
interface decode_if;
   import decode_pkg::*;

   logic [31:0]     inst;
   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [2:0]      funct3;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm;
   itype_e          itype;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic            branch;
   logic            jump;
   logic            illegal;

   modport master (
      output inst,
      input  opcode, rd, funct3, rs1, rs2, funct7, imm, itype,
      input  reg_write, mem_read, mem_write, branch, jump, illegal
   );

   modport slave (
      input  inst,
      output opcode, rd, funct3, rs1, rs2, funct7, imm, itype,
      output reg_write, mem_read, mem_write, branch, jump, illegal
   );

endinterface

// File: rtl/decode_imm_gen.sv
// rtl/decode_imm_gen.sv - combinational sign-extended immediate builder
// Ports: inst (instruction word), itype (resolved format), imm (immediate).
// R and ILLEGAL formats yield zero.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = decode_pkg::XLEN
) (
   input  logic [31:0]     inst,
   input  itype_e          itype,
   output logic [XLEN-1:0] imm
);

   // The opcode bits never contribute to an immediate.
   logic unused_opcode_bits;
   assign unused_opcode_bits = ^inst[6:0];

   always_comb begin
      imm = '0;
      case (itype)
         ITYPE_I: imm = {{20{inst[31]}}, inst[31:20]};
         ITYPE_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         ITYPE_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         ITYPE_U: imm = {inst[31:12], 12'b0};
         ITYPE_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - RV32I instruction decoder with one registered output stage
// Ports: clk, rst_n (async active-low), bus (decode_if.slave: inst in,
// decoded fields/immediate/format/control flags out). Latency 1, one word per cycle.
module decode
   import decode_pkg::*;
#(
   parameter int XLEN = decode_pkg::XLEN
) (
   input  logic     clk,
   input  logic     rst_n,
   decode_if.slave  bus
);

   logic [6:0]      op;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic            legal;
   itype_e          itype_c;
   logic            reg_write_c;
   logic            mem_read_c;
   logic            mem_write_c;
   logic            branch_c;
   logic            jump_c;
   logic [XLEN-1:0] imm_c;

   assign op = bus.inst[6:0];
   assign f3 = bus.inst[14:12];
   assign f7 = bus.inst[31:25];

   always_comb begin
      itype_c     = ITYPE_ILLEGAL;
      legal       = 1'b1;
      reg_write_c = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      branch_c    = 1'b0;
      jump_c      = 1'b0;
      case (op)
         OP_OP: begin
            itype_c     = ITYPE_R;
            reg_write_c = 1'b1;
            // Only SUB (000) and SRA (101) use the alternate funct7.
            if (!((f7 == F7_BASE) ||
                  ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))))
               legal = 1'b0;
         end
         OP_IMM: begin
            itype_c     = ITYPE_I;
            reg_write_c = 1'b1;
            // Shift-immediates reuse the upper immediate bits as funct7.
            if ((f3 == 3'b001) && (f7 != F7_BASE))
               legal = 1'b0;
            if ((f3 == 3'b101) && (f7 != F7_BASE) && (f7 != F7_ALT))
               legal = 1'b0;
         end
         OP_LOAD: begin
            itype_c     = ITYPE_I;
            reg_write_c = 1'b1;
            mem_read_c  = 1'b1;
         end
         OP_JALR: begin
            itype_c     = ITYPE_I;
            reg_write_c = 1'b1;
            jump_c      = 1'b1;
            if (f3 != 3'b000)
               legal = 1'b0;
         end
         OP_SYSTEM, OP_MISC_MEM: begin
            itype_c = ITYPE_I;
         end
         OP_STORE: begin
            itype_c     = ITYPE_S;
            mem_write_c = 1'b1;
         end
         OP_BRANCH: begin
            itype_c  = ITYPE_B;
            branch_c = 1'b1;
            if ((f3 == 3'b010) || (f3 == 3'b011))
               legal = 1'b0;
         end
         OP_LUI, OP_AUIPC: begin
            itype_c     = ITYPE_U;
            reg_write_c = 1'b1;
         end
         OP_JAL: begin
            itype_c     = ITYPE_J;
            reg_write_c = 1'b1;
            jump_c      = 1'b1;
         end
         default: legal = 1'b0;
      endcase

      // An illegal word never drives side effects downstream.
      if (!legal) begin
         itype_c     = ITYPE_ILLEGAL;
         reg_write_c = 1'b0;
         mem_read_c  = 1'b0;
         mem_write_c = 1'b0;
         branch_c    = 1'b0;
         jump_c      = 1'b0;
      end
   end

   // Fed the resolved format so illegal words get a zero immediate.
   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst  (bus.inst),
      .itype (itype_c),
      .imm   (imm_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.opcode    <= '0;
         bus.rd        <= '0;
         bus.funct3    <= '0;
         bus.rs1       <= '0;
         bus.rs2       <= '0;
         bus.funct7    <= '0;
         bus.imm       <= '0;
         bus.itype     <= ITYPE_ILLEGAL;
         bus.reg_write <= 1'b0;
         bus.mem_read  <= 1'b0;
         bus.mem_write <= 1'b0;
         bus.branch    <= 1'b0;
         bus.jump      <= 1'b0;
         bus.illegal   <= 1'b0;
      end else begin
         bus.opcode    <= op;
         bus.rd        <= bus.inst[11:7];
         bus.funct3    <= f3;
         bus.rs1       <= bus.inst[19:15];
         bus.rs2       <= bus.inst[24:20];
         bus.funct7    <= f7;
         bus.imm       <= imm_c;
         bus.itype     <= itype_c;
         bus.reg_write <= reg_write_c;
         bus.mem_read  <= mem_read_c;
         bus.mem_write <= mem_write_c;
         bus.branch    <= branch_c;
         bus.jump      <= jump_c;
         bus.illegal   <= ~legal;
      end
   end

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - self-checking bench for decode with a behavioural reference model
module tb_decode;
   import decode_pkg::*;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  funct7;
      logic [31:0] imm;
      logic [2:0]  itype;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } dec_t;

   localparam logic [31:0] W_ADD  = 32'h002081B3;
   localparam logic [31:0] W_ADDI = 32'h05408113;
   localparam logic [31:0] W_NEG  = 32'hFFF00093;
   localparam logic [31:0] W_SW   = 32'h0020A423;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   decode_if bus ();

   decode dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic dec_t observed();
      dec_t o;
      o.opcode    = bus.opcode;
      o.rd        = bus.rd;
      o.funct3    = bus.funct3;
      o.rs1       = bus.rs1;
      o.rs2       = bus.rs2;
      o.funct7    = bus.funct7;
      o.imm       = bus.imm;
      o.itype     = bus.itype;
      o.reg_write = bus.reg_write;
      o.mem_read  = bus.mem_read;
      o.mem_write = bus.mem_write;
      o.branch    = bus.branch;
      o.jump      = bus.jump;
      o.illegal   = bus.illegal;
      return o;
   endfunction

   function automatic dec_t reset_value();
      dec_t r;
      r = '0;
      r.itype = 3'd7;
      return r;
   endfunction

   // Reference decode from the instruction-set rules, using integer arithmetic
   // for the immediates.
   function automatic dec_t model(input logic [31:0] w);
      dec_t e;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      int fmt;
      bit bad;
      int v;
      op = w[6:0];
      f3 = w[14:12];
      f7 = w[31:25];
      e = '0;
      e.opcode = op;
      e.rd     = w[11:7];
      e.funct3 = f3;
      e.rs1    = w[19:15];
      e.rs2    = w[24:20];
      e.funct7 = f7;

      if (op == 7'h33) fmt = 0;
      else if (op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0F}) fmt = 1;
      else if (op == 7'h23) fmt = 2;
      else if (op == 7'h63) fmt = 3;
      else if (op inside {7'h37, 7'h17}) fmt = 4;
      else if (op == 7'h6F) fmt = 5;
      else fmt = 7;

      bad = (fmt == 7)
         || (fmt == 0 && !(f7 inside {7'h00, 7'h20}))
         || (fmt == 0 && f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}))
         || (op == 7'h13 && f3 == 3'd1 && f7 != 7'h00)
         || (op == 7'h13 && f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}))
         || (op == 7'h67 && f3 != 3'd0)
         || (fmt == 3 && f3 inside {3'd2, 3'd3});

      if (bad) begin
         e.itype   = 3'd7;
         e.illegal = 1'b1;
         return e;
      end

      e.itype     = 3'(fmt);
      e.reg_write = (fmt == 0 || fmt == 4 || fmt == 5) ||
                    (fmt == 1 && !(op inside {7'h73, 7'h0F}));
      e.mem_read  = (op == 7'h03);
      e.mem_write = (fmt == 2);
      e.branch    = (fmt == 3);
      e.jump      = (fmt == 5) || (op == 7'h67);

      case (fmt)
         1: v = int'(w[31:20]) - (w[31] ? 4096 : 0);
         2: v = int'({w[31:25], w[11:7]}) - (w[31] ? 4096 : 0);
         3: v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2
                - (w[31] ? 4096 : 0);
         4: v = int'(w[31:12]) * 4096;
         5: v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
                - (w[31] ? 1048576 : 0);
         default: v = 0;
      endcase
      e.imm = 32'(v);
      return e;
   endfunction

   task automatic step(input logic [31:0] w);
      @(negedge clk);
      bus.inst = w;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      dec_t o;
      rst_n = 1'b0;
      bus.inst = W_ADD;
      repeat (2) @(posedge clk);
      #1;
      o = observed();
      tests_run++;
      if (o !== reset_value()) begin
         tests_failed++;
         $display("FAIL reset_state: got %h required %h", o, reset_value());
      end
      tests_run++;
      if (bus.itype !== ITYPE_ILLEGAL || bus.illegal !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_itype_illegal: got itype=%0d illegal=%0b required 7/0",
                  bus.itype, bus.illegal);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      o = observed();
      tests_run++;
      if (o !== model(W_ADD)) begin
         tests_failed++;
         $display("FAIL first_edge_after_reset: got %h required %h", o, model(W_ADD));
      end
   endtask

   task automatic test_directed();
      step(W_ADD);
      tests_run++;
      if (bus.opcode !== 7'h33 || bus.rd !== 5'd3 || bus.funct3 !== 3'd0 ||
          bus.rs1 !== 5'd1 || bus.rs2 !== 5'd2 || bus.funct7 !== 7'd0 ||
          bus.itype !== 3'd0 || bus.imm !== 32'd0 || bus.reg_write !== 1'b1 ||
          bus.illegal !== 1'b0) begin
         tests_failed++;
         $display("FAIL add: got %h", observed());
      end
      step(W_ADDI);
      tests_run++;
      if (bus.opcode !== 7'h13 || bus.rd !== 5'd2 || bus.funct3 !== 3'd0 ||
          bus.rs1 !== 5'd1 || bus.imm !== 32'h54 || bus.itype !== 3'd1 ||
          bus.reg_write !== 1'b1) begin
         tests_failed++;
         $display("FAIL addi: got %h", observed());
      end
      step(W_NEG);
      tests_run++;
      if (bus.imm !== 32'hFFFFFFFF || bus.itype !== 3'd1) begin
         tests_failed++;
         $display("FAIL addi_neg: got imm=%h itype=%0d required ffffffff/1", bus.imm, bus.itype);
      end
      step(W_SW);
      tests_run++;
      if (bus.itype !== 3'd2 || bus.imm !== 32'd8 || bus.rs1 !== 5'd1 ||
          bus.rs2 !== 5'd2 || bus.mem_write !== 1'b1 || bus.reg_write !== 1'b0) begin
         tests_failed++;
         $display("FAIL sw: got %h", observed());
      end
   endtask

   task automatic test_formats();
      logic [31:0] words [10];
      dec_t o;
      words = '{32'h800000B7, 32'hFFFFF017, 32'hFE000EE3, 32'h7FF0006F, 32'h800000EF,
                32'h00002063, 32'h00001067, 32'h4000D013, 32'h40001033, 32'h0FF0000F};
      foreach (words[i]) begin
         step(words[i]);
         o = observed();
         tests_run++;
         if (o !== model(words[i])) begin
            tests_failed++;
            $display("FAIL format_%0d inst=%h: got %h required %h", i, words[i], o, model(words[i]));
         end
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [11];
      logic [31:0] w;
      dec_t o;
      int errs;
      ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
      errs = 0;
      for (int n = 0; n < 400; n++) begin
         w = $urandom;
         if ($urandom_range(0, 3) != 0)
            w[6:0] = ops[$urandom_range(0, 10)];
         if ($urandom_range(0, 1) == 1)
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         step(w);
         o = observed();
         tests_run++;
         if (o !== model(w)) begin
            tests_failed++;
            if (errs < 10)
               $display("FAIL random inst=%h: got %h required %h", w, o, model(w));
            errs++;
         end
      end
   endtask

   task automatic test_back_to_back();
      step(32'h00000000);
      tests_run++;
      if (bus.illegal !== 1'b1 || bus.reg_write !== 1'b0 || bus.mem_read !== 1'b0 ||
          bus.mem_write !== 1'b0 || bus.branch !== 1'b0 || bus.jump !== 1'b0 ||
          bus.itype !== 3'd7) begin
         tests_failed++;
         $display("FAIL zero_word: got %h", observed());
      end
      step(W_ADD);
      tests_run++;
      if (bus.illegal !== 1'b0 || bus.reg_write !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_add: got illegal=%0b reg_write=%0b required 0/1",
                  bus.illegal, bus.reg_write);
      end
   endtask

   task automatic test_midstream_reset();
      dec_t o;
      step(W_ADD);
      tests_run++;
      if (observed() !== model(W_ADD)) begin
         tests_failed++;
         $display("FAIL pre_reset_add: got %h required %h", observed(), model(W_ADD));
      end
      #3;
      rst_n = 1'b0;
      #1;
      o = observed();
      tests_run++;
      if (o !== reset_value()) begin
         tests_failed++;
         $display("FAIL async_reset: got %h required %h", o, reset_value());
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (observed() !== reset_value()) begin
         tests_failed++;
         $display("FAIL reset_hold: got %h required %h", observed(), reset_value());
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.inst = W_SW;
      #2;
      tests_run++;
      if (observed() !== reset_value()) begin
         tests_failed++;
         $display("FAIL release_before_edge: got %h required %h", observed(), reset_value());
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (observed() !== model(W_SW)) begin
         tests_failed++;
         $display("FAIL release_first_edge: got %h required %h", observed(), model(W_SW));
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      bus.inst = 32'h0;
      test_reset();
      test_directed();
      test_formats();
      test_random();
      test_back_to_back();
      test_midstream_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter XLEN, default 32, data/immediate width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 inst  input  32  RV32I instruction word, sampled every rising clk edge.
REQ-005 opcode  output  7  inst[6:0].
REQ-006 rd  output  5  inst[11:7].
REQ-007 funct3  output  3  inst[14:12].
REQ-008 rs1  output  5  inst[19:15].
REQ-009 rs2  output  5  inst[24:20].
REQ-010 funct7  output  7  inst[31:25].
REQ-011 imm  output  32  sign-extended immediate for the decoded format.
REQ-012 itype  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
REQ-013 reg_write, mem_read, mem_write, branch, jump  output  1 each  control flags.
REQ-014 illegal  output  1  instruction not recognised.

Function
REQ-015 All outputs SHALL be registered; each output reflects the inst sampled at the previous rising edge (latency 1 cycle, throughput 1 per cycle, no handshake).
REQ-016 Field outputs (REQ-005..010) SHALL be raw bit slices for every format, including illegal words.
REQ-017 Format mapping by opcode:
- 0110011 -> R
- 0010011, 0000011, 1100111, 1110011, 0001111 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- any other opcode -> ILLEGAL
REQ-018 Immediates, sign bit inst[31]:
- I: inst[31:20]
- S: {inst[31:25], inst[11:7]}
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
- U: {inst[31:12], 12'b0}
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- R and ILLEGAL: 0
REQ-019 reg_write=1 for R, U, J, and for I-type except 1110011 and 0001111.
REQ-020 mem_read=1 only for opcode 0000011; mem_write=1 only for S.
REQ-021 branch=1 only for B; jump=1 for J and opcode 1100111.
REQ-022 illegal=1 in any of these cases; when illegal=1, all control flags SHALL be 0 and itype=ILLEGAL:
- unknown opcode
- R-type with funct7 not 0000000/0100000
- R-type with funct7=0100000 and funct3 not 000/101
- opcode 0010011, funct3=001 with funct7 not 0000000
- opcode 0010011, funct3=101 with funct7 not 0000000/0100000
- opcode 1100111 with funct3 not 000
- B with funct3 010 or 011
REQ-023 The all-zero word SHALL decode as illegal.

Reset
REQ-024 While rst_n=0 all outputs SHALL be 0, except itype=ILLEGAL (7) and illegal=0.
REQ-025 Reset assertion SHALL clear outputs immediately, without waiting for a clock edge, including when asserted mid-stream.
REQ-026 The first rising edge after rst_n deasserts SHALL register the current inst.

Structure
REQ-027 A shared package SHALL hold:
- opcode constants
- the itype enumeration
- XLEN
REQ-028 Immediate generation SHALL be a combinational sub-module imm_gen (inputs inst and itype, output imm).
REQ-029 decode SHALL contain only combinational classification plus the output register stage.

Verification
REQ-030 inst=0x002081B3 (ADD x3,x1,x2) -> next edge:
- opcode=0x33, rd=3, funct3=0, rs1=1, rs2=2, funct7=0
- itype=R, imm=0, reg_write=1, illegal=0
REQ-031 inst=0x05408113 (ADDI x2,x1,0x54) -> next edge:
- opcode=0x13, rd=2, funct3=0, rs1=1
- imm=0x00000054, itype=I, reg_write=1
REQ-032 inst=0xFFF00093 (ADDI x1,x0,-1) -> imm=0xFFFFFFFF, itype=I.
REQ-033 inst=0x0020A423 (SW x2,8(x1)) -> itype=S, imm=8, rs1=1, rs2=2, mem_write=1, reg_write=0.
REQ-034 Back-to-back stimulus:
- inst=0x00000000 -> illegal=1, all control flags 0
- then 0x002081B3 on the next cycle -> illegal=0 exactly one edge later
REQ-035 Assert rst_n=0 between clock edges while outputs hold ADD results -> outputs go to reset values immediately and stay there until the first edge after release.
